// File: rtl/draw_region_pkg.sv
// Shared constants for the rectangular fill engine: screen geometry, draw opcode,
// FSM encoding and the datapath instruction layout.
package draw_region_pkg;

  localparam int         SCREEN_W_DEF    = 160;
  localparam int         SCREEN_H_DEF    = 120;
  localparam logic [2:0] OPCODE_DRAW_DEF = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_WAIT
  } state_e;

  // Instruction word, MSB first: {plot, colour, y, x, opcode}.
  function automatic int instr_width(int x_w, int y_w, int colour_w, int opcode_w);
    return 1 + colour_w + y_w + x_w + opcode_w;
  endfunction

  typedef struct packed {
    logic       plot;
    logic [2:0] colour;
    logic [6:0] y;
    logic [7:0] x;
    logic [2:0] opcode;
  } instr_t;

endpackage

// File: rtl/draw_region_cursor.sv
// Raster cursor for the fill engine: walks x across the clipped span, then wraps
// to the origin column and moves down one row. last flags the final pixel.
module region_cursor #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W:0]   w_eff_i,
  input  logic [Y_W:0]   h_eff_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);

  logic [X_W-1:0] cx_q, x_first_q, x_last_q;
  logic [Y_W-1:0] cy_q, y_last_q;

  // Clipping guarantees origin + extent never exceeds the screen, so the end
  // coordinate always fits the coordinate width.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cx_q      <= '0;
      cy_q      <= '0;
      x_first_q <= '0;
      x_last_q  <= '0;
      y_last_q  <= '0;
    end else if (load_i) begin
      cx_q      <= x0_i;
      cy_q      <= y0_i;
      x_first_q <= x0_i;
      x_last_q  <= X_W'({1'b0, x0_i} + w_eff_i - (X_W + 1)'(1));
      y_last_q  <= Y_W'({1'b0, y0_i} + h_eff_i - (Y_W + 1)'(1));
    end else if (step_i) begin
      if (cx_q == x_last_q) begin
        cx_q <= x_first_q;
        cy_q <= cy_q + Y_W'(1);
      end else begin
        cx_q <= cx_q + X_W'(1);
      end
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == x_last_q) && (cy_q == y_last_q);

endmodule

// File: rtl/draw_region.sv
// Clipped rectangle fill: issues one draw instruction per pixel to a datapath
// and waits for its acknowledge. Define DRAW_REGION_PATTERN_EN for checkerboard colouring.
module draw_region
  import draw_region_pkg::*;
#(
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  COLOUR_W    = 3,
  parameter int                  OPCODE_W    = 3,
  parameter logic [OPCODE_W-1:0] OPCODE_DRAW = OPCODE_W'(OPCODE_DRAW_DEF),
  parameter int                  SCREEN_W    = SCREEN_W_DEF,
  parameter int                  SCREEN_H    = SCREEN_H_DEF
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [X_W-1:0]                         x0,
  input  logic [Y_W-1:0]                         y0,
  input  logic [X_W-1:0]                         w,
  input  logic [Y_W-1:0]                         h,
  input  logic [COLOUR_W-1:0]                    colour,
  input  logic [COLOUR_W-1:0]                    colour_alt,
  output logic                                   finished,
  output logic [X_W+Y_W-1:0]                     pixel_count,
  input  logic                                   finished_dp,
  output logic                                   start_dp,
  output logic [OPCODE_W+X_W+Y_W+COLOUR_W:0]     instruction_dp
);

  localparam logic [X_W:0] SCR_W = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W + 1)'(SCREEN_H);

  state_e                state_q, state_d;
  logic [COLOUR_W-1:0]   colour_q;
  logic [X_W+Y_W-1:0]    count_q, count_d;
  logic [X_W:0]          x_room, w_eff;
  logic [Y_W:0]          y_room, h_eff;
  logic                  fill_ok, latch, load, step, last;
  logic [X_W-1:0]        cx;
  logic [Y_W-1:0]        cy;
  logic [COLOUR_W-1:0]   pix_colour;

  // Room to the screen edge is zero for an off-screen origin, which zeroes the
  // clipped extent and suppresses the fill without a separate test.
  always_comb begin
    x_room = '0;
    y_room = '0;
    if ({1'b0, x0} < SCR_W) x_room = SCR_W - {1'b0, x0};
    if ({1'b0, y0} < SCR_H) y_room = SCR_H - {1'b0, y0};
    w_eff   = ({1'b0, w} < x_room) ? {1'b0, w} : x_room;
    h_eff   = ({1'b0, h} < y_room) ? {1'b0, h} : y_room;
    fill_ok = (w_eff != '0) && (h_eff != '0);
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    latch   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          count_d = '0;
          if (fill_ok) begin
            load    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (finished_dp) begin
          count_d = count_q + (X_W + Y_W)'(1);
          step    = !last;
          state_d = last ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (latch) colour_q <= colour;
    end
  end

  region_cursor #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_cursor (
    .clk_i  (clock),
    .reset_i(reset),
    .load_i (load),
    .step_i (step),
    .x0_i   (x0),
    .y0_i   (y0),
    .w_eff_i(w_eff),
    .h_eff_i(h_eff),
    .cx_o   (cx),
    .cy_o   (cy),
    .last_o (last)
  );

`ifdef DRAW_REGION_PATTERN_EN
  logic [COLOUR_W-1:0] colour_alt_q;

  always_ff @(posedge clock) begin
    if (reset)      colour_alt_q <= '0;
    else if (latch) colour_alt_q <= colour_alt;
  end

  assign pix_colour = (cx[0] ^ cy[0]) ? colour_alt_q : colour_q;
`else
  logic unused_colour_alt;
  assign unused_colour_alt = ^colour_alt;
  assign pix_colour        = colour_q;
`endif

  assign finished       = (state_q == ST_IDLE);
  assign start_dp       = (state_q == ST_ISSUE) || (state_q == ST_HOLD);
  assign pixel_count    = count_q;
  assign instruction_dp = (state_q == ST_IDLE) ? '0
                        : {1'b1, pix_colour, cy, cx, OPCODE_DRAW};

endmodule
